// File: rtl/mano_ctrl_seq.sv
// Control sequencer for the Mano basic computer: sequence counter, run flip-flop,
// latched opcode decode and the per-timing-slot datapath strobes.
module mano_ctrl_seq #(
  parameter int unsigned SC_W = 3
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [2:0]           IR_OP,
  input  logic                 IR_I,
  input  logic [11:0]          IR_B,
  input  logic                 DR_ZERO,
  input  logic                 AC_ZERO,
  output logic [2**SC_W-1:0]   T,
  output logic [7:0]           D,
  output logic                 RUN,
  output logic                 AR_LD,
  output logic                 AR_INC,
  output logic                 PC_LD,
  output logic                 PC_INC,
  output logic                 DR_LD,
  output logic                 DR_INC,
  output logic                 AC_LD,
  output logic                 AC_INC,
  output logic                 AC_CLR,
  output logic                 IR_LD,
  output logic                 MEM_RD,
  output logic                 MEM_WR,
  output logic [2:0]           BUS_SEL,
  output logic [1:0]           ALU_OP,
  output logic                 SEQ_ERR
);

  localparam int unsigned T_W = 2**SC_W;

  logic [SC_W-1:0] r_sc;
  logic            r_s;
  logic [2:0]      r_opc;
  logic            r_i;
  logic            r_seq_err;

  logic            w_sc_clr;
  logic            w_hlt;
  logic            w_unused_b;

  // Register-reference bits other than CLA/INC/SZA/HLT are no-ops here
  assign w_unused_b = ^{IR_B[10:6], IR_B[4:3], IR_B[1]};

  assign T       = T_W'(1) << r_sc;
  assign D       = 8'(1) << r_opc;
  assign RUN     = r_s;
  assign SEQ_ERR = r_seq_err;

  // Strobe decode per timing slot; everything is gated by the run flip-flop
  always_comb begin
    AR_LD    = 1'b0;
    AR_INC   = 1'b0;
    PC_LD    = 1'b0;
    PC_INC   = 1'b0;
    DR_LD    = 1'b0;
    DR_INC   = 1'b0;
    AC_LD    = 1'b0;
    AC_INC   = 1'b0;
    AC_CLR   = 1'b0;
    IR_LD    = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    BUS_SEL  = 3'd0;
    ALU_OP   = 2'd0;
    w_sc_clr = 1'b0;
    w_hlt    = 1'b0;
    if (r_s) begin
      case (r_sc)
        SC_W'(0): begin
          BUS_SEL = 3'd2;
          AR_LD   = 1'b1;
        end
        SC_W'(1): begin
          BUS_SEL = 3'd7;
          MEM_RD  = 1'b1;
          IR_LD   = 1'b1;
          PC_INC  = 1'b1;
        end
        SC_W'(2): begin
          BUS_SEL = 3'd5;
          AR_LD   = 1'b1;
        end
        SC_W'(3): begin
          if (r_opc == 3'd7) begin
            w_sc_clr = 1'b1;
            if (!r_i) begin
              AC_CLR = IR_B[11];
              AC_INC = IR_B[5];
              PC_INC = IR_B[2] & AC_ZERO;
              w_hlt  = IR_B[0];
            end
          end else if (r_i) begin
            BUS_SEL = 3'd7;
            MEM_RD  = 1'b1;
            AR_LD   = 1'b1;
          end
        end
        SC_W'(4): begin
          case (r_opc)
            3'd0, 3'd1, 3'd2, 3'd6: begin
              BUS_SEL = 3'd7;
              MEM_RD  = 1'b1;
              DR_LD   = 1'b1;
            end
            3'd3: begin
              BUS_SEL  = 3'd4;
              MEM_WR   = 1'b1;
              w_sc_clr = 1'b1;
            end
            3'd4: begin
              BUS_SEL  = 3'd1;
              PC_LD    = 1'b1;
              w_sc_clr = 1'b1;
            end
            3'd5: begin
              BUS_SEL = 3'd2;
              MEM_WR  = 1'b1;
              AR_INC  = 1'b1;
            end
            default: ;
          endcase
        end
        SC_W'(5): begin
          case (r_opc)
            3'd0, 3'd1, 3'd2: begin
              AC_LD    = 1'b1;
              ALU_OP   = r_opc[1:0] + 2'd1;
              w_sc_clr = 1'b1;
            end
            3'd5: begin
              BUS_SEL  = 3'd1;
              PC_LD    = 1'b1;
              w_sc_clr = 1'b1;
            end
            3'd6: DR_INC = 1'b1;
            default: ;
          endcase
        end
        SC_W'(6): begin
          if (r_opc == 3'd6) begin
            BUS_SEL  = 3'd3;
            MEM_WR   = 1'b1;
            PC_INC   = DR_ZERO;
            w_sc_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Sequence counter, run flip-flop, opcode latch and sticky wrap fault
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sc      <= '0;
      r_s       <= 1'b0;
      r_opc     <= 3'd0;
      r_i       <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      if (r_s) begin
        r_sc <= w_sc_clr ? '0 : r_sc + SC_W'(1);
      end else begin
        r_sc <= '0;
      end
      if (w_hlt) begin
        r_s <= 1'b0;
      end else if (START) begin
        r_s <= 1'b1;
      end
      if (r_s && (r_sc == SC_W'(2))) begin
        r_opc <= IR_OP;
        r_i   <= IR_I;
      end
      if (r_s && !w_sc_clr && (r_sc == '1)) begin
        r_seq_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mano_ctrl_seq.sv
// Randomised bench for mano_ctrl_seq: each instruction is expanded into its
// micro-operation list by a reference model and replayed cycle by cycle.
module tb_mano_ctrl_seq;

  localparam int unsigned SC_W = 3;
  localparam int unsigned T_W  = 2**SC_W;

  localparam bit [16:0] M_AR_LD  = 17'h10000;
  localparam bit [16:0] M_AR_INC = 17'h08000;
  localparam bit [16:0] M_PC_LD  = 17'h04000;
  localparam bit [16:0] M_PC_INC = 17'h02000;
  localparam bit [16:0] M_DR_LD  = 17'h01000;
  localparam bit [16:0] M_DR_INC = 17'h00800;
  localparam bit [16:0] M_AC_LD  = 17'h00400;
  localparam bit [16:0] M_AC_INC = 17'h00200;
  localparam bit [16:0] M_AC_CLR = 17'h00100;
  localparam bit [16:0] M_IR_LD  = 17'h00080;
  localparam bit [16:0] M_RD     = 17'h00040;
  localparam bit [16:0] M_WR     = 17'h00020;

  logic CLK = 1'b0;
  logic RST, START, IR_I, DR_ZERO, AC_ZERO;
  logic [2:0]  IR_OP;
  logic [11:0] IR_B;
  logic [T_W-1:0] T;
  logic [7:0] D;
  logic RUN, AR_LD, AR_INC, PC_LD, PC_INC, DR_LD, DR_INC, AC_LD, AC_INC, AC_CLR;
  logic IR_LD, MEM_RD, MEM_WR, SEQ_ERR;
  logic [2:0] BUS_SEL;
  logic [1:0] ALU_OP;
  logic [16:0] w_obs;

  int n_chk  = 0;
  int n_fail = 0;
  bit [16:0] prog[$];
  int unsigned m_prev_opc = 0;
  bit m_run = 1'b0;
  bit m_err = 1'b0;

  mano_ctrl_seq #(.SC_W(SC_W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IR_OP(IR_OP), .IR_I(IR_I), .IR_B(IR_B),
    .DR_ZERO(DR_ZERO), .AC_ZERO(AC_ZERO), .T(T), .D(D), .RUN(RUN),
    .AR_LD(AR_LD), .AR_INC(AR_INC), .PC_LD(PC_LD), .PC_INC(PC_INC),
    .DR_LD(DR_LD), .DR_INC(DR_INC), .AC_LD(AC_LD), .AC_INC(AC_INC), .AC_CLR(AC_CLR),
    .IR_LD(IR_LD), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .BUS_SEL(BUS_SEL),
    .ALU_OP(ALU_OP), .SEQ_ERR(SEQ_ERR)
  );

  always #5 CLK = ~CLK;

  assign w_obs = {AR_LD, AR_INC, PC_LD, PC_INC, DR_LD, DR_INC, AC_LD, AC_INC, AC_CLR,
                  IR_LD, MEM_RD, MEM_WR, BUS_SEL, ALU_OP};

  function automatic bit [16:0] f_bus(int unsigned b);
    return 17'(b) << 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // Micro-operation list of one instruction, one entry per clock from T0
  task automatic build_prog(input int unsigned opc, input bit ind, input bit [11:0] b,
                            input bit acz, input bit drz, output bit halts);
    bit [16:0] v;
    halts = 1'b0;
    prog = {};
    prog.push_back(f_bus(2) | M_AR_LD);
    prog.push_back(f_bus(7) | M_RD | M_IR_LD | M_PC_INC);
    prog.push_back(f_bus(5) | M_AR_LD);
    if (opc == 7) begin
      v = '0;
      if (!ind) begin
        if (b[11]) v |= M_AC_CLR;
        if (b[5]) v |= M_AC_INC;
        if (b[2] && acz) v |= M_PC_INC;
        halts = b[0];
      end
      prog.push_back(v);
      return;
    end
    prog.push_back(ind ? (f_bus(7) | M_RD | M_AR_LD) : 17'h0);
    case (opc)
      0, 1, 2: begin
        prog.push_back(f_bus(7) | M_RD | M_DR_LD);
        prog.push_back(M_AC_LD | 17'(opc + 1));
      end
      3: prog.push_back(f_bus(4) | M_WR);
      4: prog.push_back(f_bus(1) | M_PC_LD);
      5: begin
        prog.push_back(f_bus(2) | M_WR | M_AR_INC);
        prog.push_back(f_bus(1) | M_PC_LD);
      end
      default: begin
        prog.push_back(f_bus(7) | M_RD | M_DR_LD);
        prog.push_back(M_DR_INC);
        prog.push_back(f_bus(3) | M_WR | (drz ? M_PC_INC : 17'h0));
      end
    endcase
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_strb"}, 32'(w_obs), 32'h0);
    check({tag, "_T"}, 32'(T), 32'h1);
    check({tag, "_D"}, 32'(D), 32'(1) << m_prev_opc);
    check({tag, "_RUN"}, 32'(RUN), 32'h0);
    check({tag, "_ERR"}, 32'(SEQ_ERR), 32'(m_err));
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
    m_run = 1'b1;
  endtask

  // Replays one instruction; abort_at selects a slot where RST is asserted mid-cycle
  task automatic run_instr(input int unsigned opc, input bit ind, input bit [11:0] b,
                           input bit acz, input bit drz, input int abort_at,
                           input bit start_hlt);
    bit halts;
    build_prog(opc, ind, b, acz, drz, halts);
    if (!m_run) pulse_start();
    for (int idx = 0; idx < prog.size(); idx++) begin
      IR_OP   = (idx == 2) ? 3'(opc) : 3'($urandom);
      IR_I    = (idx == 2) ? ind : 1'($urandom);
      IR_B    = (idx == 3) ? b : 12'($urandom);
      AC_ZERO = (idx == 3) ? acz : 1'($urandom);
      DR_ZERO = (idx == 6) ? drz : 1'($urandom);
      START   = start_hlt ? 1'b1 : 1'($urandom);
      #1;
      if (idx == abort_at) begin
        START = 1'b0;
        RST = 1'b1;
        #1;
        m_run = 1'b0;
        m_prev_opc = 0;
        m_err = 1'b0;
        check_idle("rst_mid");
        #3 RST = 1'b0;
        step();
        check_idle("rst_after");
        return;
      end
      check($sformatf("strb_op%0d_T%0d", opc, idx), 32'(w_obs), 32'(prog[idx]));
      check($sformatf("T_op%0d_T%0d", opc, idx), 32'(T), 32'(1) << idx);
      check($sformatf("D_op%0d_T%0d", opc, idx), 32'(D),
            32'(1) << ((idx < 3) ? m_prev_opc : opc));
      check("RUN_mid", 32'(RUN), 32'h1);
      check("ERR_mid", 32'(SEQ_ERR), 32'(m_err));
      step();
    end
    START = 1'b0;
    m_prev_opc = opc;
    if (halts) m_run = 1'b0;
    #1;
    check($sformatf("T_end_op%0d", opc), 32'(T), 32'h1);
    check($sformatf("RUN_end_op%0d", opc), 32'(RUN), 32'(m_run));
  endtask

  initial begin
    bit [11:0] rb;
    RST = 1'b1; START = 1'b0; IR_OP = '0; IR_I = 1'b0; IR_B = '0;
    DR_ZERO = 1'b0; AC_ZERO = 1'b0;
    #2;
    check_idle("reset");
    #1 RST = 1'b0;
    step();
    check_idle("idle");

    run_instr(6, 1'b0, 12'h000, 1'b0, 1'b0, 5, 1'b0);
    run_instr(2, 1'b0, 12'h123, 1'b0, 1'b0, -1, 1'b0);
    run_instr(5, 1'b1, 12'h456, 1'b0, 1'b0, -1, 1'b0);
    run_instr(6, 1'b0, 12'h000, 1'b0, 1'b1, -1, 1'b0);
    run_instr(6, 1'b0, 12'h000, 1'b0, 1'b0, -1, 1'b0);
    run_instr(7, 1'b0, 12'h805, 1'b1, 1'b0, -1, 1'b1);
    step();
    check_idle("hlt_idle");

    for (int n = 0; n < 40; n++) begin
      rb = 12'($urandom);
      if ($urandom_range(0, 3) != 0) rb[0] = 1'b0;
      run_instr($urandom_range(0, 7), 1'($urandom), rb, 1'($urandom), 1'($urandom),
                -1, 1'($urandom));
    end

    // Suppress the internal clear so the counter walks through every slot and wraps
    if (!m_run) pulse_start();
    IR_OP = 3'd6; IR_I = 1'b0; IR_B = 12'h000; START = 1'b0;
    force dut.w_sc_clr = 1'b0;
    for (int k = 0; k < T_W; k++) begin
      #1;
      check($sformatf("wrap_T%0d", k), 32'(T), 32'(1) << k);
      check("wrap_err_pre", 32'(SEQ_ERR), 32'(m_err));
      step();
    end
    #1;
    release dut.w_sc_clr;
    m_err = 1'b1;
    m_prev_opc = 6;
    check("wrap_T0", 32'(T), 32'h1);
    check("wrap_err_set", 32'(SEQ_ERR), 32'h1);
    run_instr(1, 1'b0, 12'h000, 1'b0, 1'b0, -1, 1'b0);
    run_instr(4, 1'b1, 12'h000, 1'b0, 1'b0, -1, 1'b0);

    RST = 1'b1;
    #1;
    m_run = 1'b0; m_prev_opc = 0; m_err = 1'b0;
    check_idle("final_rst");
    #2 RST = 1'b0;
    step();
    check_idle("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mano_ctrl_seq.md
# mano_ctrl_seq

Parametrised control sequencer for the Mano basic computer: owns the sequence counter (SC), the run flip-flop (S), and the latched opcode decode. It generates every register load/increment/clear strobe, the memory read/write strobes and the common-bus select for fetch, indirect-address, memory-reference and a subset of register-reference instructions. It sits between the IR/DR/AC status bits and the datapath registers (AR, PC, DR, AC, IR) and replaces the per-register fixed timing tie-offs.

## Interface
- SC_W, 3: sequence-counter width, minimum 3; timing vector width is 2**SC_W.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle pulse; sets S.
- IR_OP  in  3  IR[14:12]; sampled at T2.
- IR_I  in  1  IR[15]; sampled at T2.
- IR_B  in  12  IR[11:0]; used combinationally at T3 for register-reference.
- DR_ZERO  in  1  DR == 0.
- AC_ZERO  in  1  AC == 0.
- T  out  2**SC_W  one-hot decode of SC.
- D  out  8  one-hot decode of latched opcode.
- RUN  out  1  S flip-flop.
- AR_LD, AR_INC, PC_LD, PC_INC, DR_LD, DR_INC, AC_LD, AC_INC, AC_CLR, IR_LD  out  1 each  register strobes.
- MEM_RD, MEM_WR  out  1  memory strobes.
- BUS_SEL  out  3  common-bus source: 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 memory; 0 when idle.
- ALU_OP  out  2  AC input function: 0 none, 1 AND, 2 ADD, 3 transfer DR.
- SEQ_ERR  out  1  sticky sequencing-fault flag.

## Operation
- Registered state: SC[SC_W-1:0], S, OPC[2:0], I. All strobes and BUS_SEL/ALU_OP are combinational from this state plus IR_B, DR_ZERO and AC_ZERO, and are gated by S (all 0 when S=0).
- SC increments each cycle while S=1; it is cleared to 0 by SC_CLR (internal); it holds at 0 while S=0.
- T0: BUS_SEL=2, AR_LD.
- T1: BUS_SEL=7, MEM_RD, IR_LD, PC_INC.
- T2: BUS_SEL=5, AR_LD; OPC<=IR_OP and I<=IR_I on the closing edge.
- T3, D7, I=0 (register-reference): AC_CLR if IR_B[11]; AC_INC if IR_B[5]; PC_INC if IR_B[2] and AC_ZERO; S<=0 if IR_B[0]; SC_CLR. Other IR_B bits are no-ops. Multiple set bits act together.
- T3, D7, I=1 (I/O): no strobes; SC_CLR.
- T3, not D7, I=1: BUS_SEL=7, MEM_RD, AR_LD. Not D7, I=0: no strobes.
- D0 AND / D1 ADD: T4 BUS_SEL=7, MEM_RD, DR_LD; T5 AC_LD, ALU_OP=1/2, SC_CLR.
- D2 LDA: T4 as above; T5 AC_LD, ALU_OP=3, SC_CLR.
- D3 STA: T4 BUS_SEL=4, MEM_WR, SC_CLR.
- D4 BUN: T4 BUS_SEL=1, PC_LD, SC_CLR.
- D5 BSA: T4 BUS_SEL=2, MEM_WR, AR_INC; T5 BUS_SEL=1, PC_LD, SC_CLR.
- D6 ISZ: T4 BUS_SEL=7, MEM_RD, DR_LD; T5 DR_INC; T6 BUS_SEL=3, MEM_WR, PC_INC if DR_ZERO, SC_CLR.
- Wrap-around: if SC reaches 2**SC_W-1 with no SC_CLR, SC wraps to 0 and SEQ_ERR sets. SEQ_ERR clears only on RST. With SC_W>=3 no legal instruction wraps.
- START while S=1 is ignored. If HLT and START occur in the same cycle, HLT wins (S<=0).

## Timing
- Reset values: SC=0, S=0, OPC=0, I=0, SEQ_ERR=0. Outputs: T=one-hot bit 0, D=8'h01, RUN=0, all strobes 0, BUS_SEL=0, ALU_OP=0.
- START sampled at edge k gives RUN=1 from k. T0 strobes are active in cycle k+1.
- Instruction length in cycles, from T0 to SC_CLR cycle inclusive: register-ref/I/O 4; STA and BUN 5; AND, ADD, LDA and BSA 6; ISZ 7. Add 0 for indirect (the T3 slot is always spent).
- RST asserted mid-instruction forces reset values immediately, independent of CLK. No partial strobe is held.
- After HLT, S=0 from the following edge. SC is cleared at the same edge.

## Test plan
- Reset mid-ISZ at T5 -> next sample shows SC=0, RUN=0, all strobes 0, SEQ_ERR=0.
- START, IR_OP=3'b010, IR_I=0 -> T0..T5 strobes as specified, ALU_OP=3 with AC_LD at T5, SC back to 0 after 6 cycles.
- IR_OP=3'b101, IR_I=1 -> MEM_RD+AR_LD at T3, MEM_WR+AR_INC at T4, PC_LD at T5.
- ISZ with DR_ZERO=1 at T6 -> PC_INC=1 with MEM_WR. Repeat with DR_ZERO=0 -> PC_INC=0.
- Register-ref IR_B=12'h805 (CLA, SZA, HLT), AC_ZERO=1 -> at T3 AC_CLR=1 and PC_INC=1, RUN=0 after the edge. START in the same cycle leaves RUN=0.
- SC_W=3 with OPC forced to D6 and SC_CLR suppressed (force) -> SC wraps 7->0, SEQ_ERR=1 and remains set until RST.
